// File: rtl/aqua_fetch_pkg.sv
// Shared widths, fetch-entry layout and address helpers for the aqua fetch unit.
package aqua_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int MAX_ISSUE_W = 8;

    // Widest entry layout; the top declares the same field order narrowed to its ISSUE_W.
    typedef struct packed {
        logic [XLEN-1:0]             pc;
        logic [ILEN*MAX_ISSUE_W-1:0] instr;
        logic [MAX_ISSUE_W-1:0]      mask;
    } fetch_entry_max_t;

    function automatic logic [XLEN-1:0] group_align(input logic [XLEN-1:0] addr,
                                                    input int              off_w);
        return addr & ~((XLEN'(1) << off_w) - XLEN'(1));
    endfunction

endpackage

// File: rtl/aqua_fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; storage is not reset, only pointers and count.
module aqua_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/aqua_fetch_nw.sv
// Fetch front end: PC sequencing, one-deep in-flight tag, redirect kill, and a decode queue.
module aqua_fetch_nw
    import aqua_fetch_pkg::*;
#(
    parameter int          ISSUE_W  = 2,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_sel,
    input  logic [XLEN-1:0]         i_bru,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [ILEN*ISSUE_W-1:0] imem_rdata,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [XLEN-1:0]         o_pc,
    output logic [ILEN*ISSUE_W-1:0] o_instr,
    output logic [ISSUE_W-1:0]      o_instr_vld
);

    localparam int GB    = 4 * ISSUE_W;
    localparam int OFF_W = $clog2(GB);
    localparam int CW    = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(QDEPTH);

    typedef struct packed {
        logic [XLEN-1:0]         pc;
        logic [ILEN*ISSUE_W-1:0] instr;
        logic [ISSUE_W-1:0]      mask;
    } fetch_entry_t;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [XLEN-1:0]    tag_pc_q, tag_pc_d;
    logic [ISSUE_W-1:0] tag_mask_q, tag_mask_d;
    logic [CW-1:0]      count;
    logic [CW:0]        occupancy;
    logic [ISSUE_W-1:0] lane_mask;
    int                 lane_idx;
    logic               push, pop, empty;
    fetch_entry_t       wr_entry, rd_entry;

    // Lanes before the entry point of a mid-group target carry no valid instruction.
    always_comb begin
        lane_idx  = int'((pc_q >> 2) & XLEN'(ISSUE_W - 1));
        lane_mask = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            lane_mask[i] = (i >= lane_idx);
        end
    end

    // In-flight reads are counted against queue space so a response always has a slot.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
        imem_req  = !rst && !pc_sel && (occupancy < DEPTH_LIM);
        imem_addr = group_align(pc_q, OFF_W);
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = 1'b0;
        tag_pc_d   = tag_pc_q;
        tag_mask_d = tag_mask_q;
        if (pc_sel) begin
            pc_d = i_bru & ~XLEN'(3);
        end else if (imem_req) begin
            pc_d       = imem_addr + XLEN'(GB);
            inflight_d = 1'b1;
            tag_pc_d   = imem_addr;
            tag_mask_d = lane_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC & ~XLEN'(3);
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_pc_q   <= tag_pc_d;
        tag_mask_q <= tag_mask_d;
    end

    // A redirect kills the returning response and any pop in the same cycle.
    always_comb begin
        push     = inflight_q && !pc_sel;
        pop      = o_vld && i_rdy && !pc_sel;
        wr_entry = '{pc: tag_pc_q, instr: imem_rdata, mask: tag_mask_q};
    end

    aqua_fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (pc_sel),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .empty (empty),
        .count (count)
    );

    assign o_vld       = !empty;
    assign o_pc        = rd_entry.pc;
    assign o_instr     = rd_entry.instr;
    assign o_instr_vld = rd_entry.mask;

endmodule

// File: tb/tb_aqua_fetch_nw.sv
// Bench for aqua_fetch_nw: directed fetch scenarios plus a randomized run against a stream model.
module tb_aqua_fetch_nw;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         pc_sel, i_rdy, imem_req, o_vld;
    logic [31:0]  i_bru, imem_addr, o_pc;
    logic [63:0]  imem_rdata, o_instr;
    logic [1:0]   o_instr_vld;

    logic         pc_sel4, i_rdy4, imem_req4, o_vld4;
    logic [31:0]  i_bru4, imem_addr4, o_pc4;
    logic [127:0] imem_rdata4, o_instr4;
    logic [3:0]   o_instr_vld4;

    int tests = 0;
    int fails = 0;

    aqua_fetch_nw #(.ISSUE_W(2), .QDEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .i_bru(i_bru),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_pc(o_pc), .o_instr(o_instr),
        .o_instr_vld(o_instr_vld)
    );

    aqua_fetch_nw #(.ISSUE_W(4), .QDEPTH(4), .RESET_PC(32'h0)) u_dut4 (
        .clk(clk), .rst(rst), .pc_sel(pc_sel4), .i_bru(i_bru4),
        .imem_req(imem_req4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
        .o_vld(o_vld4), .i_rdy(i_rdy4), .o_pc(o_pc4), .o_instr(o_instr4),
        .o_instr_vld(o_instr_vld4)
    );

    // Instruction memory: each word holds its own byte address, returned one cycle after the request.
    always @(posedge clk) begin
        if (imem_req)  imem_rdata  <= {imem_addr + 32'd4, imem_addr};
        if (imem_req4) imem_rdata4 <= {imem_addr4 + 32'd12, imem_addr4 + 32'd8,
                                       imem_addr4 + 32'd4, imem_addr4};
    end

    function automatic logic [63:0] grp2(input logic [31:0] a);
        return {a + 32'd4, a};
    endfunction

    task automatic do_reset();
        rst = 1'b1; pc_sel = 1'b0; i_bru = '0; i_rdy = 1'b0;
        pc_sel4 = 1'b0; i_bru4 = '0; i_rdy4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_sel = 1'b0; i_bru = '0; i_rdy = 1'b1;
        pc_sel4 = 1'b0; i_bru4 = '0; i_rdy4 = 1'b1;
        @(negedge clk); #1;
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL reset_o_vld got=%b exp=0", o_vld); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=0", imem_addr); end
        tests++; if (o_vld4 !== 1'b0 || imem_req4 !== 1'b0) begin
            fails++; $display("FAIL reset_w4 got vld=%b req=%b exp=0,0", o_vld4, imem_req4);
        end
        repeat (2) @(negedge clk); #1;
        tests++; if (o_vld !== 1'b0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL reset_hold got vld=%b req=%b exp=0,0", o_vld, imem_req);
        end
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk); rst = 1'b0; i_rdy = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(k * 8)) begin
                fails++; $display("FAIL stream_req%0d got req=%b addr=%h exp=1,%h", k, imem_req, imem_addr, k * 8);
            end
            tests++;
            if (k < 2) begin
                if (o_vld !== 1'b0) begin fails++; $display("FAIL stream_early_vld%0d got=%b exp=0", k, o_vld); end
            end else if (o_vld !== 1'b1 || o_pc !== 32'((k - 2) * 8) || o_instr_vld !== 2'b11 ||
                         o_instr !== grp2(32'((k - 2) * 8))) begin
                fails++; $display("FAIL stream_head%0d got vld=%b pc=%h m=%b i=%h exp pc=%h m=11",
                                  k, o_vld, o_pc, o_instr_vld, o_instr, (k - 2) * 8);
            end
        end
    endtask

    task automatic test_backpressure();
        int          reqs;
        int          n;
        logic        saw_req;
        logic [31:0] got [4];
        do_reset();
        reqs = 0;
        @(negedge clk); rst = 1'b0; i_rdy = 1'b0; #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            if (imem_req === 1'b1) reqs++;
        end
        tests++; if (reqs != 4) begin fails++; $display("FAIL bp_req_count got=%0d exp=4", reqs); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_req_stop got=%b exp=0", imem_req); end
        tests++; if (o_vld !== 1'b1 || o_pc !== 32'h0) begin
            fails++; $display("FAIL bp_head got vld=%b pc=%h exp=1,0", o_vld, o_pc);
        end
        n = 0; saw_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); i_rdy = 1'b1; #1;
            if (o_vld === 1'b1 && n < 4) begin got[n] = o_pc; n++; end
            if (imem_req === 1'b1) saw_req = 1'b1;
        end
        tests++; if (n != 4) begin fails++; $display("FAIL bp_drain_count got=%0d exp=4", n); end
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (j < n && got[j] !== 32'(j * 8)) begin
                fails++; $display("FAIL bp_drain%0d got=%h exp=%h", j, got[j], j * 8);
            end
        end
        tests++; if (!saw_req) begin fails++; $display("FAIL bp_resume got=0 exp=1"); end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset();
        @(negedge clk); rst = 1'b0; i_rdy = 1'b1;
        repeat (4) @(negedge clk);
        pc_sel = 1'b1; i_bru = 32'h34; #1;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_req_blocked got=%b exp=0", imem_req); end
        @(negedge clk); pc_sel = 1'b0; #1;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h30 || o_vld !== 1'b0) begin
            fails++; $display("FAIL redir_addr got req=%b addr=%h vld=%b exp=1,30,0", imem_req, imem_addr, o_vld);
        end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin @(negedge clk); #1; if (o_vld === 1'b1) found = 1'b1; end
        tests++; if (!found || o_pc !== 32'h30 || o_instr_vld !== 2'b10 || o_instr !== grp2(32'h30)) begin
            fails++; $display("FAIL redir_head got vld=%b pc=%h m=%b exp=1,30,10", o_vld, o_pc, o_instr_vld);
        end
        @(negedge clk); #1;
        tests++; if (o_vld !== 1'b1 || o_pc !== 32'h38 || o_instr_vld !== 2'b11) begin
            fails++; $display("FAIL redir_next got vld=%b pc=%h m=%b exp=1,38,11", o_vld, o_pc, o_instr_vld);
        end
    endtask

    task automatic test_kill();
        logic found;
        do_reset();
        @(negedge clk); rst = 1'b0; i_rdy = 1'b1;
        @(negedge clk); pc_sel = 1'b1; i_bru = 32'h4;
        @(negedge clk); pc_sel = 1'b0; #1;
        tests++; if (o_vld !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL kill_restart got vld=%b req=%b addr=%h exp=0,1,0", o_vld, imem_req, imem_addr);
        end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin @(negedge clk); #1; if (o_vld === 1'b1) found = 1'b1; end
        tests++; if (!found || o_pc !== 32'h0 || o_instr_vld !== 2'b10) begin
            fails++; $display("FAIL kill_first got vld=%b pc=%h m=%b exp=1,0,10", o_vld, o_pc, o_instr_vld);
        end
    endtask

    task automatic test_flush_full();
        logic found;
        do_reset();
        @(negedge clk); rst = 1'b0; i_rdy = 1'b0;
        repeat (8) @(negedge clk);
        i_rdy = 1'b1; pc_sel = 1'b1; i_bru = 32'h100; #1;
        tests++; if (o_vld !== 1'b1 || o_pc !== 32'h0) begin
            fails++; $display("FAIL flush_full_head got vld=%b pc=%h exp=1,0", o_vld, o_pc);
        end
        @(negedge clk); pc_sel = 1'b0; #1;
        tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL flush_empty got=%b exp=0", o_vld); end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin @(negedge clk); #1; if (o_vld === 1'b1) found = 1'b1; end
        tests++; if (!found || o_pc !== 32'h100) begin
            fails++; $display("FAIL flush_first got vld=%b pc=%h exp=1,100", o_vld, o_pc);
        end
        @(negedge clk); #1;
        tests++; if (o_vld !== 1'b1 || o_pc !== 32'h108) begin
            fails++; $display("FAIL flush_second got vld=%b pc=%h exp=1,108", o_vld, o_pc);
        end
    endtask

    task automatic test_wide();
        logic found;
        do_reset();
        @(negedge clk); rst = 1'b0; i_rdy4 = 1'b0; pc_sel4 = 1'b1; i_bru4 = 32'h4; #1;
        tests++; if (imem_req4 !== 1'b0) begin fails++; $display("FAIL w4_redir_req got=%b exp=0", imem_req4); end
        @(negedge clk); pc_sel4 = 1'b0; #1;
        tests++; if (imem_req4 !== 1'b1 || imem_addr4 !== 32'h0) begin
            fails++; $display("FAIL w4_addr got req=%b addr=%h exp=1,0", imem_req4, imem_addr4);
        end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin @(negedge clk); #1; if (o_vld4 === 1'b1) found = 1'b1; end
        tests++;
        if (!found || o_pc4 !== 32'h0 || o_instr_vld4 !== 4'b1110 ||
            o_instr4 !== {32'hC, 32'h8, 32'h4, 32'h0}) begin
            fails++; $display("FAIL w4_head got vld=%b pc=%h m=%b exp=1,0,1110", o_vld4, o_pc4, o_instr_vld4);
        end
        repeat (2) @(negedge clk);
        #2; rst = 1'b1; #1;
        tests++; if (o_vld4 !== 1'b0 || imem_req4 !== 1'b0) begin
            fails++; $display("FAIL w4_async_rst got vld=%b req=%b exp=0,0", o_vld4, imem_req4);
        end
        @(negedge clk); rst = 1'b0; i_rdy4 = 1'b1; #1;
        tests++; if (imem_req4 !== 1'b1 || imem_addr4 !== 32'h0 || o_vld4 !== 1'b0) begin
            fails++; $display("FAIL w4_release got req=%b addr=%h vld=%b exp=1,0,0", imem_req4, imem_addr4, o_vld4);
        end
        @(negedge clk); #1;
        tests++; if (o_vld4 !== 1'b0) begin fails++; $display("FAIL w4_no_stale got=%b exp=0", o_vld4); end
        @(negedge clk); #1;
        tests++; if (o_vld4 !== 1'b1 || o_pc4 !== 32'h0 || o_instr_vld4 !== 4'b1111) begin
            fails++; $display("FAIL w4_refetch got vld=%b pc=%h m=%b exp=1,0,1111", o_vld4, o_pc4, o_instr_vld4);
        end
    endtask

    // Model: accepted groups form a contiguous stream from the last redirect target.
    task automatic test_random();
        logic [31:0] exp_addr;
        logic [1:0]  exp_mask;
        logic        prev_hold, prev_redirect;
        logic [31:0] hold_pc;
        logic [63:0] hold_instr;
        logic [1:0]  hold_mask;
        int          accepted;
        do_reset();
        exp_addr = 32'h0; exp_mask = 2'b11;
        prev_hold = 1'b0; prev_redirect = 1'b0; accepted = 0;
        hold_pc = '0; hold_instr = '0; hold_mask = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst    = 1'b0;
            i_rdy  = ($urandom_range(0, 9) < 7);
            pc_sel = ($urandom_range(0, 19) == 0);
            i_bru  = $urandom & 32'h0000_0FFF;
            #1;
            if (prev_redirect) begin
                tests++; if (o_vld !== 1'b0) begin fails++; $display("FAIL rnd_flush c=%0d got=%b exp=0", c, o_vld); end
            end
            if (prev_hold) begin
                tests++;
                if (o_vld !== 1'b1 || o_pc !== hold_pc || o_instr !== hold_instr || o_instr_vld !== hold_mask) begin
                    fails++; $display("FAIL rnd_stable c=%0d got vld=%b pc=%h exp=1,%h", c, o_vld, o_pc, hold_pc);
                end
            end
            if (pc_sel) begin
                tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rnd_req_redir c=%0d got=%b exp=0", c, imem_req); end
            end
            if (o_vld === 1'b1 && i_rdy && !pc_sel) begin
                tests++;
                if (o_pc !== exp_addr || o_instr_vld !== exp_mask || o_instr !== grp2(exp_addr)) begin
                    fails++; $display("FAIL rnd_accept c=%0d got pc=%h m=%b i=%h exp pc=%h m=%b i=%h",
                                      c, o_pc, o_instr_vld, o_instr, exp_addr, exp_mask, grp2(exp_addr));
                end
                exp_addr = exp_addr + 32'd8;
                exp_mask = 2'b11;
                accepted++;
            end
            if (pc_sel) begin
                exp_addr = i_bru & ~32'h7;
                exp_mask = i_bru[2] ? 2'b10 : 2'b11;
            end
            prev_redirect = pc_sel;
            prev_hold     = (o_vld === 1'b1) && !i_rdy && !pc_sel;
            hold_pc       = o_pc;
            hold_instr    = o_instr;
            hold_mask     = o_instr_vld;
        end
        tests++; if (accepted < 100) begin fails++; $display("FAIL rnd_progress got=%0d exp>=100", accepted); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_kill();
        test_flush_full();
        test_wide();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
